// File: rtl/wb_port_arb_pkg.sv
// Shared widths, constants and parameter defaults for the register-file write-port arbiter.
package wb_port_arb_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegW     = 32;

  localparam logic [RegW-1:0]     ZeroWord    = '0;
  localparam logic [RegAddrW-1:0] ZeroRegAddr = '0;
  localparam logic                WriteEnable = 1'b1;
  localparam logic                RstEnable   = 1'b1;

  localparam int unsigned WbArbDepth  = 2;
  localparam int unsigned WbStarveMax = 4;

endpackage

// File: rtl/wport_fifo.sv
// Buffer of pending long-latency writes: each slot is {live, addr, data}; a killed or
// popped slot has live=0, so live bits alone describe the buffered writes still owed.
module wport_fifo
  import wb_port_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [RegAddrW-1:0] push_addr,
  input  logic [RegW-1:0]     push_data,
  input  logic                pop,
  input  logic                kill_en,
  input  logic [RegAddrW-1:0] kill_addr,
  input  logic [RegAddrW-1:0] match_addr1,
  input  logic [RegAddrW-1:0] match_addr2,
  output logic                full,
  output logic                empty,
  output logic                head_live,
  output logic [RegAddrW-1:0] head_addr,
  output logic [RegW-1:0]     head_data,
  output logic                match1,
  output logic                match2
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrInc = (AW+1)'(1);

  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]       wr_idx, rd_idx;
  logic [DEPTH-1:0]    live_q;
  logic [RegAddrW-1:0] addr_q [DEPTH];
  logic [RegW-1:0]     data_q [DEPTH];

  assign wr_idx    = wr_ptr_q[AW-1:0];
  assign rd_idx    = rd_ptr_q[AW-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign head_live = !empty && live_q[rd_idx];
  assign head_addr = addr_q[rd_idx];
  assign head_data = data_q[rd_idx];

  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == match_addr1)) match1 = 1'b1;
      if (live_q[i] && (addr_q[i] == match_addr2)) match2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      live_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && live_q[i] && (addr_q[i] == kill_addr)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_idx] <= 1'b0;
        rd_ptr_q       <= rd_ptr_q + PtrInc;
      end
      // The push slot is never the pop slot: pushes are blocked while full.
      if (push) begin
        live_q[wr_idx] <= 1'b1;
        wr_ptr_q       <= wr_ptr_q + PtrInc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_idx] <= push_addr;
      data_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: writeback owns the port, buffered long-latency results
// fill idle cycles, and a starved buffer head raises a registered stall request.
module wb_port_arb
  import wb_port_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = WbArbDepth,
  parameter int unsigned STARVE_MAX = WbStarveMax
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_we,
  input  logic [RegAddrW-1:0] wb_waddr,
  input  logic [RegW-1:0]     wb_wdata,
  input  logic                lu_valid,
  input  logic [RegAddrW-1:0] lu_waddr,
  input  logic [RegW-1:0]     lu_wdata,
  output logic                lu_ready,
  input  logic [RegAddrW-1:0] raddr1,
  input  logic [RegAddrW-1:0] raddr2,
  output logic                pend_hit1,
  output logic                pend_hit2,
  output logic                we,
  output logic [RegAddrW-1:0] waddr,
  output logic [RegW-1:0]     wdata,
  output logic                stallreq
);

  localparam int unsigned     CntW         = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMaxCnt = CntW'(STARVE_MAX);
  localparam logic [CntW-1:0] CntInc       = CntW'(1);

  logic                in_rst, wb_eff, push, pop;
  logic                full, empty, head_live, match1, match2;
  logic [RegAddrW-1:0] head_addr;
  logic [RegW-1:0]     head_data;
  logic [CntW-1:0]     starve_cnt_q, starve_cnt_d;
  logic                stallreq_q, stallreq_d;

  assign in_rst   = (rst == RstEnable);
  assign wb_eff   = (wb_we == WriteEnable) && (wb_waddr != ZeroRegAddr);
  assign lu_ready = !in_rst && !full;
  // A zero-destination result completes its handshake but is dropped.
  assign push     = lu_valid && lu_ready && (lu_waddr != ZeroRegAddr);
  // A killed head drains even while writeback holds the port.
  assign pop      = !empty && (!head_live || !wb_eff);

  wport_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (lu_waddr),
    .push_data   (lu_wdata),
    .pop         (pop),
    .kill_en     (wb_eff),
    .kill_addr   (wb_waddr),
    .match_addr1 (raddr1),
    .match_addr2 (raddr2),
    .full        (full),
    .empty       (empty),
    .head_live   (head_live),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .match1      (match1),
    .match2      (match2)
  );

  always_comb begin
    we    = 1'b0;
    waddr = ZeroRegAddr;
    wdata = ZeroWord;
    if (!in_rst) begin
      if (wb_eff) begin
        we    = WriteEnable;
        waddr = wb_waddr;
        wdata = wb_wdata;
      end else if (head_live) begin
        we    = WriteEnable;
        waddr = head_addr;
        wdata = head_data;
      end
    end
  end

  assign pend_hit1 = !in_rst && (raddr1 != ZeroRegAddr) && match1;
  assign pend_hit2 = !in_rst && (raddr2 != ZeroRegAddr) && match2;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    stallreq_d   = stallreq_q;
    if (empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMaxCnt) begin
      starve_cnt_d = starve_cnt_q + CntInc;
    end
    if (pop) begin
      stallreq_d = 1'b0;
    end else if (starve_cnt_d == StarveMaxCnt) begin
      stallreq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      starve_cnt_q <= '0;
      stallreq_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stallreq_q   <= stallreq_d;
    end
  end

  assign stallreq = stallreq_q;

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb: expected port writes are queued as stimulus is
// driven and compared in order by a monitor on every cycle the port writes.
module tb_wb_port_arb;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic [4:0]  raddr1, raddr2;
  logic        pend_hit1, pend_hit2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stallreq;

  int  n_checks = 0;
  int  n_pass   = 0;
  wr_t exp_q[$];

  wb_port_arb dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .lu_valid  (lu_valid),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .lu_ready  (lu_ready),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .pend_hit1 (pend_hit1),
    .pend_hit2 (pend_hit2),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .stallreq  (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // An effective writeback appears on the port in the same cycle it is driven.
  task automatic set_wb(input logic e, input logic [4:0] a, input logic [31:0] d);
    wb_we    = e;
    wb_waddr = a;
    wb_wdata = d;
    if (e && (a != 5'd0) && !rst) push_exp(a, d);
  endtask

  task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v;
    lu_waddr = a;
    lu_wdata = d;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (we) begin
      if (exp_q.size() == 0) begin
        check("extra_we", we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", waddr, e.addr);
        check("wr_data", wdata, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    set_wb(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    next();
    next();
    sample();
    check("rst_we", we, 1'b0);
    check("rst_ready", lu_ready, 1'b0);

    // Idle writeback: buffered result writes on the following cycle.
    next();
    rst = 1'b0;
    raddr1 = 5'd5;
    set_lu(1'b1, 5'd5, 32'hDEAD_BEEF);
    sample();
    check("idle_ready", lu_ready, 1'b1);
    check("idle_hit_pre", pend_hit1, 1'b0);
    next();
    set_lu(1'b0, 5'd0, 32'd0);
    push_exp(5'd5, 32'hDEAD_BEEF);
    sample();
    check("idle_hit", pend_hit1, 1'b1);
    check("idle_we", we, 1'b1);
    next();
    sample();
    check("idle_hit_post", pend_hit1, 1'b0);
    check("idle_drain", exp_q.size(), 0);

    // Starvation: r7 waits behind continuous r3 writebacks.
    raddr2 = 5'd7;
    for (int i = 0; i < 5; i++) begin
      next();
      set_wb(1'b1, 5'd3, 32'h300 + i);
      set_lu(i == 0, 5'd7, 32'h77);
      sample();
      check("starve_stall_lo", stallreq, 1'b0);
      check("starve_hit", pend_hit2, i > 0);
    end
    next();
    set_wb(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    push_exp(5'd7, 32'h77);
    sample();
    check("starve_stall_hi", stallreq, 1'b1);
    check("starve_we", we, 1'b1);
    next();
    sample();
    check("starve_stall_clr", stallreq, 1'b0);
    check("starve_drain", exp_q.size(), 0);

    // Full FIFO: third result held until space frees.
    raddr1 = 5'd1;
    for (int i = 0; i < 4; i++) begin
      next();
      set_wb(1'b1, 5'd4, 32'h400 + i);
      if (i == 0)      set_lu(1'b1, 5'd1, 32'h101);
      else if (i == 1) set_lu(1'b1, 5'd2, 32'h102);
      else             set_lu(1'b1, 5'd8, 32'h108);
      sample();
      check("full_ready", lu_ready, i < 2);
    end
    next();
    set_wb(1'b0, 5'd0, 32'd0);
    push_exp(5'd1, 32'h101);
    sample();
    check("full_ready_pop", lu_ready, 1'b0);
    next();
    push_exp(5'd2, 32'h102);
    sample();
    check("full_ready_free", lu_ready, 1'b1);
    next();
    set_lu(1'b0, 5'd0, 32'd0);
    push_exp(5'd8, 32'h108);
    sample();
    check("full_hit_r1", pend_hit1, 1'b0);
    next();
    sample();
    check("full_drain", exp_q.size(), 0);

    // WAW kill: younger writeback to r9 cancels the buffered r9.
    raddr1 = 5'd9;
    next();
    set_wb(1'b1, 5'd10, 32'hA0);
    set_lu(1'b1, 5'd9, 32'h11);
    sample();
    check("waw_hit_pre", pend_hit1, 1'b0);
    next();
    set_lu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd9, 32'h22);
    sample();
    check("waw_hit", pend_hit1, 1'b1);
    check("waw_wb_data", wdata, 32'h22);
    next();
    set_wb(1'b0, 5'd0, 32'd0);
    sample();
    check("waw_hit_post", pend_hit1, 1'b0);
    check("waw_no_we", we, 1'b0);
    next();
    sample();
    check("waw_drain", exp_q.size(), 0);

    // Zero destinations: LU r0 is dropped, WB r0 leaves the port free.
    next();
    set_lu(1'b1, 5'd0, 32'h55);
    sample();
    check("zero_ready", lu_ready, 1'b1);
    next();
    set_lu(1'b1, 5'd12, 32'hCC);
    set_wb(1'b1, 5'd0, 32'hFFFF);
    sample();
    check("zero_we", we, 1'b0);
    check("zero_ready2", lu_ready, 1'b1);
    next();
    set_lu(1'b0, 5'd0, 32'd0);
    push_exp(5'd12, 32'hCC);
    sample();
    check("zero_port", we, 1'b1);
    next();
    set_wb(1'b0, 5'd0, 32'd0);
    sample();
    check("zero_drain", exp_q.size(), 0);

    // Reset mid-operation with two entries buffered and stall raised.
    raddr1 = 5'd1;
    raddr2 = 5'd2;
    for (int i = 0; i < 6; i++) begin
      next();
      set_wb(1'b1, 5'd4, 32'h500 + i);
      if (i == 0)      set_lu(1'b1, 5'd1, 32'h601);
      else if (i == 1) set_lu(1'b1, 5'd2, 32'h602);
      else             set_lu(1'b0, 5'd0, 32'd0);
    end
    sample();
    check("mid_stall", stallreq, 1'b1);
    check("mid_hit1", pend_hit1, 1'b1);
    next();
    rst = 1'b1;
    set_wb(1'b1, 5'd4, 32'h5FF);
    sample();
    check("mid_rst_we", we, 1'b0);
    check("mid_rst_waddr", waddr, 5'd0);
    check("mid_rst_wdata", wdata, 32'd0);
    check("mid_rst_ready", lu_ready, 1'b0);
    check("mid_rst_hit1", pend_hit1, 1'b0);
    check("mid_rst_hit2", pend_hit2, 1'b0);
    next();
    sample();
    check("mid_rst_stall", stallreq, 1'b0);
    next();
    rst = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    sample();
    check("post_rst_ready", lu_ready, 1'b1);
    check("post_rst_hit1", pend_hit1, 1'b0);
    check("post_rst_we", we, 1'b0);
    next();
    next();
    sample();
    check("post_rst_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arb.md
# wb_port_arb

Write-port arbiter for the 32×32 register file's single write port. Shares the port between the pipeline writeback stage, which has fixed priority and is never back-pressured, and a long-latency unit (divider, multiplier or load-return), which completes with a valid/ready handshake. Long-latency results wait in a small FIFO until the writeback stage leaves the port idle. The block also raises a stall request on starvation and reports in-flight destination hits to the ID stage. It sits between MEM/WB, the long-latency unit and `regfile`, and drives regfile `we`/`waddr`/`wdata`.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `STARVE_MAX`, default 4: number of consecutive cycles a non-empty FIFO head may go unserved before `stallreq` asserts.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high (`RstEnable`).
- `wb_we`  in  1  writeback stage write request.
- `wb_waddr`  in  `RegAddrBus` (5)  writeback destination register.
- `wb_wdata`  in  `RegBus` (32)  writeback data.
- `lu_valid`  in  1  long-latency result valid.
- `lu_waddr`  in  5  long-latency destination register.
- `lu_wdata`  in  32  long-latency result data.
- `lu_ready`  out  1  FIFO can accept; equals `!full`.
- `raddr1`, `raddr2`  in  5  ID-stage read addresses.
- `pend_hit1`, `pend_hit2`  out  1  read address matches a live buffered entry.
- `we`, `waddr`, `wdata`  out  1/5/32  regfile write port.
- `stallreq`  out  1  to pipeline `ctrl`; requests a writeback bubble.

## Operation
- **WB priority.** A writeback is *effective* when `wb_we` is 1 and `wb_waddr` ≠ 0. An effective writeback drives the port: `we`=1, `waddr`=`wb_waddr`, `wdata`=`wb_wdata`, combinationally.
- **Serving the FIFO.**
  - If there is no effective writeback and the FIFO head is live, the port carries the head and the head pops that cycle.
  - If the head is killed, it pops without using the port; `we` stays 0 unless WB is active.
  - A killed head pops regardless of WB activity.
- **Idle port.** `we`=0, `waddr`=0, `wdata`=0.
- **Enqueue.** An entry is pushed when `lu_valid` && `lu_ready`.
  - If `lu_waddr`=0, the handshake completes but nothing is enqueued.
  - `lu_ready` depends only on registered `full`. When the FIFO is full, nothing is pushed even if a pop occurs that cycle.
- **WAW kill.** An effective writeback whose `wb_waddr` matches a live FIFO entry marks that entry killed, at the clock edge. The writeback instruction is always the younger one. The write on the port this cycle is unaffected.
- **Pending hits.** `pend_hit1` = (`raddr1` ≠ 0) && `raddr1` matches any live entry; this includes the head being popped this cycle. `pend_hit2` is the same for `raddr2`. Both are combinational.
- **Starvation.**
  - `starve_cnt` counts cycles in which the FIFO head is live but not popped. It clears on any pop and whenever the FIFO is empty.
  - `stallreq` is registered. It sets on the edge after which `starve_cnt` == `STARVE_MAX`. It clears on the edge at which the head pops.
- **Flow control.** FIFO pointers are `log2(DEPTH)+1` bits; wrap-around follows the MSB-compare full/empty rule. There is no overflow or underflow path.

## Timing
- Port outputs have zero latency from `wb_*` and from the FIFO head.
- Enqueue-to-write latency is at least 1 cycle: an entry pushed at edge N can write at cycle N+1 at the earliest.
- The regfile's own bypass covers the port-cycle write. `pend_hit` covers all older buffered writes.
- **Reset.** While `rst`=1: `we`/`waddr`/`wdata`/`pend_hit*`/`lu_ready`=0. On the reset edge, `stallreq`, `starve_cnt`, pointers and all valid/kill bits clear. Buffered entries are discarded when reset arrives mid-operation.
- **Simultaneous push and pop** when not full: both take effect; occupancy is unchanged.
- **WB kill of the current head** when the head cannot pop because WB owns the port: the head becomes killed and drops next cycle without writing.

## Structure
- Reuse `RegAddrBus`, `RegBus`, `ZeroWord`, `ZeroRegAddr`, `WriteEnable` and `RstEnable` from `defines.v`.
- Add `WbArbDepth` and `WbStarveMax` to `defines.v` as the parameter defaults.
- One sub-module, `wport_fifo`: DEPTH × {live, addr, data} storage, push/pop, kill-by-address and two match ports. The top level holds the arbitration mux, the starvation counter and `stallreq`.

## Test plan
- **Idle WB.** Reset, then `lu_valid`=1 with r5/0xDEAD_BEEF for 1 cycle, `wb_we`=0 → next cycle `we`=1, `waddr`=5, `wdata`=0xDEADBEEF; `pend_hit1`=1 for `raddr1`=5 only during that cycle.
- **Starvation.** `wb_we`=1 (r3) every cycle, one LU push to r7 → FIFO holds; `stallreq` rises after 4 unserved cycles. Drop `wb_we` → r7 written; `stallreq` falls the next edge.
- **Full FIFO.** Push r1 then r2 while WB is busy → `lu_ready`=0. Third `lu_valid` is held. Release WB → r1, r2 written in order, then the third result.
- **WAW kill.** Buffer r9=0x11, then WB writes r9=0x22 → r9 is never written with 0x11; `pend_hit` for r9 drops after the kill edge.
- **Zero address.** LU push with `lu_waddr`=0 → `lu_ready` handshake completes, FIFO stays empty, `we` stays 0. WB with `wb_waddr`=0 → port is free for a buffered entry.
- **Reset mid-operation.** `rst`=1 with 2 entries and `stallreq`=1 → all outputs 0 during reset; after release the FIFO is empty and no buffered write appears.
